// File: rtl/reg_file_param_pkg.sv
// Shared definitions for the parametrised register file: clear-FSM state
// encodings and the default stack-pointer initial value.
package reg_file_param_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_SWEEP = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

  localparam logic [31:0] SP_INIT_DEFAULT = 32'h0000_1FFF;

endpackage

// File: rtl/reg_file_clear_ctl.sv
// Clear engine for reg_file_param: walks every index once, asserting the sweep
// write strobe, then pulses clear_done for a single cycle.
module reg_file_clear_ctl
  import reg_file_param_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};

  clr_state_e        state_r;
  clr_state_e        state_nx_s;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] cnt_nx_s;
  logic              busy_r;
  logic              done_r;

  // Next-state and counter logic; clear_req only matters in IDLE
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      CLR_IDLE: begin
        if (clear_req) begin
          state_nx_s = CLR_SWEEP;
          cnt_nx_s   = IDX_ZERO;
        end else begin
          state_nx_s = CLR_IDLE;
        end
      end
      CLR_SWEEP: begin
        // Counter wraps naturally to 0 after the last index
        cnt_nx_s = cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (cnt_r == LAST_IDX) begin
          state_nx_s = CLR_DONE;
        end else begin
          state_nx_s = CLR_SWEEP;
        end
      end
      CLR_DONE: begin
        state_nx_s = CLR_IDLE;
      end
      default: begin
        state_nx_s = CLR_IDLE;
        cnt_nx_s   = IDX_ZERO;
      end
    endcase
  end

  // State, counter and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= CLR_IDLE;
      cnt_r   <= IDX_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      busy_r  <= (state_nx_s == CLR_SWEEP);
      done_r  <= (state_nx_s == CLR_DONE);
    end
  end

  assign busy       = busy_r;
  assign clear_done = done_r;
  assign sweep_we   = (state_r == CLR_SWEEP);
  assign sweep_idx  = cnt_r;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one write port,
// clear engine. Define REG_FILE_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_param
  import reg_file_param_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 32,
  parameter int          ZERO_REG = 1,
  parameter int          SP_INDEX = 29,
  parameter logic [31:0] SP_INIT  = SP_INIT_DEFAULT,
  localparam int         ADDR_W   = $clog2(DEPTH)
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] Read_Reg_1,
  input  logic [ADDR_W-1:0] Read_Reg_2,
  output logic [DATA_W-1:0] Read_Data_1,
  output logic [DATA_W-1:0] Read_Data_2,
  input  logic [ADDR_W-1:0] Write_Reg,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic              Reg_Write,
  input  logic              Clear_Req,
  output logic              Busy,
  output logic              Clear_Done
);

  localparam logic [ADDR_W-1:0] IDX_ZERO  = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic [DATA_W-1:0] regs_r [DEPTH];
  logic              busy_s;
  logic              sweep_we_s;
  logic [ADDR_W-1:0] sweep_idx_s;
  logic              wr_ok_s;
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;

  function automatic logic [DATA_W-1:0] rst_val(input logic [ADDR_W-1:0] idx);
    if (idx == ADDR_W'(SP_INDEX)) begin
      return DATA_W'(SP_INIT);
    end else begin
      return DATA_ZERO;
    end
  endfunction

  reg_file_clear_ctl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_ctl (
    .clk        (Clock),
    .rst_n      (Reset_n),
    .clear_req  (Clear_Req),
    .busy       (busy_s),
    .clear_done (Clear_Done),
    .sweep_we   (sweep_we_s),
    .sweep_idx  (sweep_idx_s)
  );

  assign Busy    = busy_s;
  assign wr_ok_s = Reg_Write && !busy_s && !((ZERO_REG != 0) && (Write_Reg == IDX_ZERO));

  // Storage: sweep writes take the port while busy, external writes otherwise
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= rst_val(ADDR_W'(i));
      end
    end else if (sweep_we_s) begin
      regs_r[sweep_idx_s] <= rst_val(sweep_idx_s);
    end else if (wr_ok_s) begin
      regs_r[Write_Reg] <= Write_Data;
    end
  end

  // Read port 1
  always_comb begin
    if ((ZERO_REG != 0) && (Read_Reg_1 == IDX_ZERO)) begin
      rd1_s = DATA_ZERO;
`ifdef REG_FILE_BYPASS_EN
    end else if (wr_ok_s && (Read_Reg_1 == Write_Reg)) begin
      rd1_s = Write_Data;
`endif
    end else begin
      rd1_s = regs_r[Read_Reg_1];
    end
  end

  // Read port 2
  always_comb begin
    if ((ZERO_REG != 0) && (Read_Reg_2 == IDX_ZERO)) begin
      rd2_s = DATA_ZERO;
`ifdef REG_FILE_BYPASS_EN
    end else if (wr_ok_s && (Read_Reg_2 == Write_Reg)) begin
      rd2_s = Write_Data;
`endif
    end else begin
      rd2_s = regs_r[Read_Reg_2];
    end
  end

  assign Read_Data_1 = rd1_s;
  assign Read_Data_2 = rd2_s;

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param (default parameters) against an
// array-based reference model; honours REG_FILE_BYPASS_EN when defined.
module tb_reg_file_param;

  localparam int          SP_IDX = 29;
  localparam logic [31:0] SP_VAL = 32'h0000_1FFF;

  logic        Clock;
  logic        Reset_n;
  logic [4:0]  Read_Reg_1;
  logic [4:0]  Read_Reg_2;
  logic [31:0] Read_Data_1;
  logic [31:0] Read_Data_2;
  logic [4:0]  Write_Reg;
  logic [31:0] Write_Data;
  logic        Reg_Write;
  logic        Clear_Req;
  logic        Busy;
  logic        Clear_Done;

  logic [31:0] model [32];
  int          vectors;
  int          miscompares;
  int          busy_cnt;
  int          done_cnt;
  logic [31:0] done_wr_val;

  reg_file_param dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .Read_Reg_1  (Read_Reg_1),
    .Read_Reg_2  (Read_Reg_2),
    .Read_Data_1 (Read_Data_1),
    .Read_Data_2 (Read_Data_2),
    .Write_Reg   (Write_Reg),
    .Write_Data  (Write_Data),
    .Reg_Write   (Reg_Write),
    .Clear_Req   (Clear_Req),
    .Busy        (Busy),
    .Clear_Done  (Clear_Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = (i == SP_IDX) ? SP_VAL : 32'h0;
  endtask

  // Model view of an index: register 0 is hardwired to zero
  function automatic logic [31:0] expect_rd(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : model[idx];
  endfunction

  task automatic wr(input logic [4:0] idx, input logic [31:0] data);
    Reg_Write  = 1'b1;
    Write_Reg  = idx;
    Write_Data = data;
    @(posedge Clock);
    #1;
    Reg_Write = 1'b0;
    if (idx != 5'd0) model[idx] = data;
  endtask

  task automatic rd_check(input string tag, input logic [4:0] idx);
    Read_Reg_1 = idx;
    Read_Reg_2 = 5'($urandom_range(0, 31));
    #1;
    chk({tag, "_p1"}, Read_Data_1, expect_rd(idx));
    chk({tag, "_p2"}, Read_Data_2, expect_rd(Read_Reg_2));
  endtask

  task automatic rd_all(input string tag);
    for (int i = 0; i < 32; i++) rd_check(tag, 5'(i));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset_n     = 1'b1;
    Read_Reg_1  = 5'd0;
    Read_Reg_2  = 5'd0;
    Write_Reg   = 5'd0;
    Write_Data  = 32'h0;
    Reg_Write   = 1'b0;
    Clear_Req   = 1'b0;
    model_reset();

    // 1. Asynchronous reset before any clock edge
    #1 Reset_n = 1'b0;
    Read_Reg_1 = 5'd29;
    Read_Reg_2 = 5'd7;
    #1;
    chk("rst_sp", Read_Data_1, SP_VAL);
    chk("rst_r7", Read_Data_2, 32'h0);
    chk("rst_busy", {31'h0, Busy}, 32'h0);
    chk("rst_done", {31'h0, Clear_Done}, 32'h0);
    @(posedge Clock); #3 Reset_n = 1'b1;
    @(posedge Clock); #1;
    rd_all("rst_all");

    // 2. Directed writes, including the zero register
    @(posedge Clock); #1;
    wr(5'd5, 32'hDEAD_BEEF);
    Read_Reg_1 = 5'd5; Read_Reg_2 = 5'd5; #1;
    chk("wr5_p1", Read_Data_1, 32'hDEAD_BEEF);
    chk("wr5_p2", Read_Data_2, 32'hDEAD_BEEF);
    wr(5'd0, 32'h0000_1234);
    rd_check("wr0", 5'd0);

    // 6. Same-cycle forwarding (or its absence)
    wr(5'd3, 32'h0000_1111);
    Reg_Write = 1'b1; Write_Reg = 5'd3; Write_Data = 32'h0000_CAFE;
    Read_Reg_1 = 5'd3; Read_Reg_2 = 5'd0; #1;
`ifdef REG_FILE_BYPASS_EN
    chk("byp_p1", Read_Data_1, 32'h0000_CAFE);
`else
    chk("byp_p1", Read_Data_1, 32'h0000_1111);
`endif
    chk("byp_zero", Read_Data_2, 32'h0);
    @(posedge Clock); #1;
    Reg_Write = 1'b0;
    model[3] = 32'h0000_CAFE;
    rd_check("byp_after", 5'd3);

    // 3/4. Fill, then sweep with a write issued in IDLE alongside Clear_Req
    for (int i = 0; i < 32; i++) wr(5'(i), 32'hA5A5_A5A5);
    Clear_Req = 1'b1;
    Reg_Write = 1'b1; Write_Reg = 5'd4; Write_Data = 32'h0000_4444;
    @(posedge Clock); #1;
    Clear_Req = 1'b0;
    Reg_Write = 1'b0;
    busy_cnt    = 0;
    done_cnt    = 0;
    done_wr_val = 32'h0000_7777;
    for (int c = 0; c < 40; c++) begin
      if (Busy) busy_cnt++;
      if (Clear_Done) done_cnt++;
      if (c == 3) begin
        chk("swp_busy_c3", {31'h0, Busy}, 32'h1);
        Reg_Write = 1'b1; Write_Reg = 5'd7; Write_Data = 32'h0000_0055;
      end else if (Clear_Done) begin
        chk("swp_done_c", c, 32);
        Reg_Write = 1'b1; Write_Reg = 5'd9; Write_Data = done_wr_val;
      end else begin
        Reg_Write = 1'b0;
      end
      @(posedge Clock); #1;
    end
    Reg_Write = 1'b0;
    chk("swp_busy_cycles", busy_cnt, 32);
    chk("swp_done_pulses", done_cnt, 1);
    model_reset();
    model[9] = done_wr_val;
    rd_all("swp_all");

    // 5. Reset in the middle of a sweep
    wr(5'd12, 32'h0BAD_F00D);
    Clear_Req = 1'b1;
    @(posedge Clock); #1;
    Clear_Req = 1'b0;
    repeat (10) @(posedge Clock);
    #2 Reset_n = 1'b0;
    model_reset();
    #1;
    chk("mid_busy", {31'h0, Busy}, 32'h0);
    chk("mid_done", {31'h0, Clear_Done}, 32'h0);
    rd_check("mid_r12", 5'd12);
    rd_check("mid_sp", 5'd29);
    @(posedge Clock); #3 Reset_n = 1'b1;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge Clock); #1;
      if (Busy) busy_cnt++;
      if (Clear_Done) done_cnt++;
    end
    chk("mid_no_busy", busy_cnt, 0);
    chk("mid_no_done", done_cnt, 0);
    rd_all("mid_all");

    // Randomised writes and reads against the model
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 2) != 0) wr(5'($urandom_range(0, 31)), $urandom);
      rd_check("rnd", 5'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
